// File: rtl/label_allocator.sv
// Bump allocator for label-table entries: reserves a data-memory region per label,
// optionally zero-fills it, and writes {base, count, type} into the label table.
module label_allocator #(
  parameter int          LBID_W    = 6,
  parameter logic [15:0] MEM_BASE  = 16'h0000,
  parameter logic [15:0] MEM_LIMIT = 16'hffff
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_all,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [LBID_W-1:0] req_lbid,
  input  logic [7:0]        req_type,
  input  logic [15:0]       req_count,
  input  logic              req_zero,
  output logic              tbl_we,
  output logic [LBID_W-1:0] tbl_idx,
  output logic [15:0]       tbl_base,
  output logic [15:0]       tbl_count,
  output logic [7:0]        tbl_type,
  output logic              mem_we,
  output logic [15:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              resp_valid,
  output logic [1:0]        resp_err,
  output logic [15:0]       resp_base,
  output logic [15:0]       free_ptr
);

  // state  | meaning
  // IDLE   | waiting for a request or clear_all
  // CHECK  | validate type, count and remaining space
  // TBLWR  | write label-table entry, bump free_ptr
  // FILL   | zero one region word per cycle
  // RESP   | one-cycle completion pulse

  // Label type codes; UNDEFINED (0) and anything above CODE are rejected.
  localparam logic [7:0] LBTYPE_VPTR = 8'd1;
  localparam logic [7:0] LBTYPE_CODE = 8'd14;

  // One past the last allocatable address, in 17 bits so a full-top allocation is legal.
  localparam logic [16:0] LIM_END = {1'b0, MEM_LIMIT} + 17'd1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_TBLWR, S_FILL, S_RESP} state_t;

  state_t              state, state_nxt;
  logic [LBID_W-1:0]   lbid_q;
  logic [7:0]          type_q;
  logic [15:0]         count_q;
  logic                zero_q;
  logic [15:0]         base_q;
  logic [15:0]         fill_addr;
  logic [15:0]         fill_left;
  logic [1:0]          err_q;
  logic [1:0]          chk_err;
  logic [16:0]         end_ptr;

  assign end_ptr = {1'b0, free_ptr} + {1'b0, count_q};

  always_comb begin
    chk_err = 2'd0;
    if (type_q < LBTYPE_VPTR || type_q > LBTYPE_CODE) chk_err = 2'd1;
    else if (count_q == 16'd0)                        chk_err = 2'd2;
    else if (end_ptr > LIM_END)                       chk_err = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    tbl_we     = 1'b0;
    tbl_idx    = '0;
    tbl_base   = 16'd0;
    tbl_count  = 16'd0;
    tbl_type   = 8'd0;
    mem_we     = 1'b0;
    mem_addr   = 16'd0;
    mem_wdata  = 32'd0;
    resp_valid = 1'b0;
    resp_err   = 2'd0;
    resp_base  = 16'd0;
    unique case (state)
      S_IDLE: begin
        req_ready = ~clear_all;
        if (req_valid && !clear_all) state_nxt = S_CHECK;
      end
      S_CHECK: state_nxt = (chk_err != 2'd0) ? S_RESP : S_TBLWR;
      S_TBLWR: begin
        tbl_we    = 1'b1;
        tbl_idx   = lbid_q;
        tbl_base  = free_ptr;
        tbl_count = count_q;
        tbl_type  = type_q;
        state_nxt = zero_q ? S_FILL : S_RESP;
      end
      S_FILL: begin
        mem_we   = 1'b1;
        mem_addr = fill_addr;
        if (fill_left == 16'd1) state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_base  = (err_q == 2'd0) ? base_q : 16'd0;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      free_ptr  <= MEM_BASE;
      lbid_q    <= '0;
      type_q    <= 8'd0;
      count_q   <= 16'd0;
      zero_q    <= 1'b0;
      base_q    <= 16'd0;
      fill_addr <= 16'd0;
      fill_left <= 16'd0;
      err_q     <= 2'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (clear_all) free_ptr <= MEM_BASE;
          else if (req_valid) begin
            lbid_q  <= req_lbid;
            type_q  <= req_type;
            count_q <= req_count;
            zero_q  <= req_zero;
          end
        end
        S_CHECK: err_q <= chk_err;
        S_TBLWR: begin
          base_q    <= free_ptr;
          fill_addr <= free_ptr;
          fill_left <= count_q;
          free_ptr  <= end_ptr[15:0];
        end
        S_FILL: begin
          fill_addr <= fill_addr + 16'd1;
          fill_left <= fill_left - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_label_allocator.sv
// Randomized bench for label_allocator: each request is predicted from a simple
// free-pointer model and checked cycle by cycle against the expected transaction shape.
module tb_label_allocator;

  localparam logic [7:0] T_UNDEF  = 8'd0;
  localparam logic [7:0] T_VPTR   = 8'd1;
  localparam logic [7:0] T_SINT32 = 8'd6;
  localparam logic [7:0] T_CODE   = 8'd14;

  logic        clk = 1'b0;
  logic        reset_n, clear_all, req_valid, req_ready, req_zero;
  logic [5:0]  req_lbid, tbl_idx;
  logic [7:0]  req_type, tbl_type;
  logic [15:0] req_count, tbl_base, tbl_count, mem_addr, resp_base, free_ptr;
  logic        tbl_we, mem_we, resp_valid;
  logic [31:0] mem_wdata;
  logic [1:0]  resp_err;

  int n_vec = 0;
  int n_err = 0;
  int model_fp = 0;

  always #5 clk = ~clk;

  label_allocator dut (
    .clk(clk), .reset_n(reset_n), .clear_all(clear_all),
    .req_valid(req_valid), .req_ready(req_ready), .req_lbid(req_lbid),
    .req_type(req_type), .req_count(req_count), .req_zero(req_zero),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_base(tbl_base),
    .tbl_count(tbl_count), .tbl_type(tbl_type), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_base(resp_base), .free_ptr(free_ptr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one request (called just after a posedge, DUT idle) and follows it to the response.
  task automatic run_req(input logic [5:0] lbid, input logic [7:0] typ,
                         input logic [15:0] cnt, input bit zero);
    int exp_err, exp_base, lat, n;
    n = int'(cnt);
    if (typ < 1 || typ > 14)         exp_err = 1;
    else if (n == 0)                 exp_err = 2;
    else if (model_fp + n > 65536)   exp_err = 3;
    else                             exp_err = 0;
    exp_base = (exp_err == 0) ? model_fp : 0;
    lat = (exp_err != 0) ? 2 : (3 + (zero ? n : 0));

    req_valid = 1'b1; req_lbid = lbid; req_type = typ; req_count = cnt; req_zero = zero;
    @(negedge clk);
    chk("req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_lbid  = 6'($urandom); req_type = 8'($urandom);
    req_count = 16'($urandom); req_zero = 1'($urandom);

    for (int cyc = 1; cyc <= lat; cyc++) begin
      bit e_tbl, e_mem;
      @(negedge clk);
      e_tbl = (exp_err == 0) && (cyc == 2);
      e_mem = (exp_err == 0) && zero && (cyc >= 3) && (cyc < 3 + n);
      chk("tbl_we", {31'd0, tbl_we}, {31'd0, e_tbl});
      chk("mem_we", {31'd0, mem_we}, {31'd0, e_mem});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, (cyc == lat)});
      if (e_tbl) begin
        chk("tbl_idx", {26'd0, tbl_idx}, {26'd0, lbid});
        chk("tbl_base", {16'd0, tbl_base}, 32'(exp_base));
        chk("tbl_count", {16'd0, tbl_count}, {16'd0, cnt});
        chk("tbl_type", {24'd0, tbl_type}, {24'd0, typ});
      end
      if (e_mem) begin
        chk("mem_addr", {16'd0, mem_addr}, 32'((exp_base + cyc - 3) % 65536));
        chk("mem_wdata", mem_wdata, 32'd0);
      end
      if (cyc == lat) begin
        chk("resp_err", {30'd0, resp_err}, 32'(exp_err));
        chk("resp_base", {16'd0, resp_base}, 32'(exp_base));
      end
    end
    if (exp_err == 0) model_fp = (model_fp + n) % 65536;
    chk("free_ptr", {16'd0, free_ptr}, 32'(model_fp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; clear_all = 1'b0; req_valid = 1'b0;
    req_lbid = '0; req_type = '0; req_count = '0; req_zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_free_ptr", {16'd0, free_ptr}, 32'd0);
    chk("rst_tbl_we", {31'd0, tbl_we}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_resp", {29'd0, resp_valid, resp_err}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // directed sequence
    run_req(6'd0, T_CODE, 16'd4, 1'b0);
    run_req(6'd1, T_SINT32, 16'd3, 1'b1);
    run_req(6'd2, T_UNDEF, 16'd0, 1'b0);
    run_req(6'd3, T_VPTR, 16'd0, 1'b0);
    run_req(6'd4, T_VPTR, 16'hFFF0 - 16'd7, 1'b0);
    run_req(6'd5, T_VPTR, 16'd17, 1'b0);
    run_req(6'd6, T_VPTR, 16'd16, 1'b0);
    run_req(6'd7, T_VPTR, 16'd1, 1'b0);

    // clear_all beats a simultaneous request; the request is taken the following cycle
    req_valid = 1'b1; req_lbid = 6'd9; req_type = T_CODE; req_count = 16'd2; req_zero = 1'b0;
    clear_all = 1'b1;
    @(negedge clk);
    chk("clr_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    clear_all = 1'b0;
    model_fp = 0;
    @(negedge clk);
    chk("clr_free_ptr", {16'd0, free_ptr}, 32'd0);
    chk("clr_no_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      chk("clr_req_tbl", {31'd0, tbl_we}, {31'd0, cyc == 2});
      chk("clr_req_resp", {31'd0, resp_valid}, {31'd0, cyc == 3});
    end
    model_fp = 2;
    chk("clr_req_fp", {16'd0, free_ptr}, 32'(model_fp));
    @(posedge clk);
    #1;

    // reset in the middle of a fill
    req_valid = 1'b1; req_lbid = 6'd10; req_type = T_SINT32; req_count = 16'd6; req_zero = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_fill_we", {31'd0, mem_we}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rstfill_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rstfill_fp", {16'd0, free_ptr}, 32'd0);
    chk("rstfill_ready", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstfill_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_fp = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // random traffic
    for (int t = 0; t < 60; t++) begin
      logic [15:0] cnt;
      bit          zero;
      if ($urandom_range(0, 9) == 0) begin
        clear_all = 1'b1;
        @(posedge clk);
        #1;
        clear_all = 1'b0;
        model_fp = 0;
      end
      zero = 1'($urandom);
      if (!zero && $urandom_range(0, 3) == 0) cnt = 16'($urandom);
      else                                    cnt = 16'($urandom_range(0, 8));
      run_req(6'($urandom), 8'($urandom_range(0, 16)), cnt, zero);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
